// File: rtl/toggle_pulse_gen.sv
// Purpose : turns a raw, bouncing push-button level into clean one-cycle
//           toggle pulses for a T flip-flop, with optional auto-repeat while held.
// Latency : first pulse appears DEBOUNCE+3 edges after btn_in rises; no backpressure
//           (t_out is a fire-and-forget strobe, pulses suppressed by enable are dropped).
//
// Ports:
//   clk         - system clock, rising edge
//   reset_n     - asynchronous active-low reset
//   btn_in      - raw asynchronous button level (may bounce)
//   enable      - 0 suppresses t_out and counting; the FSM keeps tracking the button
//   t_out       - registered single-cycle toggle pulse
//   btn_level   - registered debounced button level
//   pulse_count - number of t_out pulses issued, wraps modulo 256

module toggle_pulse_gen #(
  parameter int CNT_W         = 16,
  parameter int DEBOUNCE      = 1000,
  parameter int REPEAT_DELAY  = 50000,
  parameter int REPEAT_PERIOD = 10000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_in,
  input  logic       enable,
  output logic       t_out,
  output logic       btn_level,
  output logic [7:0] pulse_count
);

  // Terminal counts for the shared timer (one cycle before each interval ends).
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    PRESSED    = 3'd2,
    REPEAT     = 3'd3,
    DB_RELEASE = 3'd4
  } state_t;

  // Two-flop synchronizer; only btn_s is used by the FSM.
  logic s1;
  logic btn_s;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             fire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1    <= btn_in;
      btn_s <= s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= CNT_ZERO;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic. A low btn_s is always tested before any timer expiry
  // so a release coinciding with a repeat deadline never emits a pulse.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = btn_level;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = DB_PRESS;
          cnt_nxt   = CNT_ZERO;
        end
      end
      DB_PRESS: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (cnt == DB_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = CNT_ZERO;
          level_nxt = 1'b1;
          fire      = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt = DB_RELEASE;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == RD_LAST) begin
          // Without auto-repeat the timer parks at its terminal value.
          if (REPEAT_EN) begin
            state_nxt = REPEAT;
            cnt_nxt   = CNT_ZERO;
            fire      = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      REPEAT: begin
        if (!btn_s) begin
          state_nxt = DB_RELEASE;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == RP_LAST) begin
          cnt_nxt = CNT_ZERO;
          fire    = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      DB_RELEASE: begin
        if (btn_s) begin
          // Release was a glitch: back to held, repeat delay starts over.
          state_nxt = PRESSED;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == DB_LAST) begin
          state_nxt = IDLE;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // Output registers. A pulse decision made while enable=0 is simply lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_out       <= 1'b0;
      btn_level   <= 1'b0;
      pulse_count <= 8'd0;
    end else begin
      t_out     <= fire & enable;
      btn_level <= level_nxt;
      if (fire && enable) begin
        pulse_count <= pulse_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Purpose : directed self-checking bench for toggle_pulse_gen.
// Two instances share all inputs: u_single (no auto-repeat) and u_repeat
// (auto-repeat, delay 10, period 5); both debounce over 4 cycles.

module tb_toggle_pulse_gen;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_in  = 1'b0;
  logic       enable  = 1'b1;

  logic       t_out0, btn_level0;
  logic [7:0] pulse_count0;
  logic       t_out1, btn_level1;
  logic [7:0] pulse_count1;

  toggle_pulse_gen #(
    .CNT_W(8), .DEBOUNCE(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .REPEAT_EN(1'b0)
  ) u_single (
    .clk(clk), .reset_n(reset_n), .btn_in(btn_in), .enable(enable),
    .t_out(t_out0), .btn_level(btn_level0), .pulse_count(pulse_count0)
  );

  toggle_pulse_gen #(
    .CNT_W(8), .DEBOUNCE(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .REPEAT_EN(1'b1)
  ) u_repeat (
    .clk(clk), .reset_n(reset_n), .btn_in(btn_in), .enable(enable),
    .t_out(t_out1), .btn_level(btn_level1), .pulse_count(pulse_count1)
  );

  always #5 clk = ~clk;

  // Rising-edge counter; read at falling edges, where it equals the
  // number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   q0[$];
  int   q1[$];
  logic prev0 = 1'b0;
  logic prev1 = 1'b0;
  int   adj_err = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  int base, p0, r, fall, drop;
  int exp_off[7] = '{0, 10, 15, 20, 25, 30, 35};

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance n falling edges, logging the edge number of every t_out pulse.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (t_out0) begin
        q0.push_back(cyc);
        if (prev0) adj_err++;
      end
      if (t_out1) begin
        q1.push_back(cyc);
        if (prev1) adj_err++;
      end
      prev0 = t_out0;
      prev1 = t_out1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    btn_in  = 1'b0;
    step(3);
    check("rst_single", {t_out0, btn_level0, pulse_count0}, 0);
    check("rst_repeat", {t_out1, btn_level1, pulse_count1}, 0);
    reset_n = 1'b1;
    q0.delete();
    q1.delete();
    prev0 = 1'b0;
    prev1 = 1'b0;
  endtask

  // Wait (bounded) for the first u_repeat pulse and check its latency from b.
  task automatic wait_first1(input string tag, input int b, output int p);
    for (int i = 0; i < 30 && q1.size() == 0; i++) step(1);
    if (q1.size() == 0) begin
      check({tag, "_timeout"}, 0, 1);
      p = cyc;
    end else begin
      p = q1[0];
      check(tag, p - b, 7);
    end
  endtask

  initial begin
    // Single press, no auto-repeat
    do_reset();
    btn_in = 1'b1;
    base   = cyc;
    step(20);
    check("single_cnt", q0.size(), 1);
    if (q0.size() > 0) check("single_lat", q0[0] - base, 7);
    check("single_lvl", btn_level0, 1);
    check("single_pc", pulse_count0, 1);
    btn_in = 1'b0;
    step(12);
    check("single_rel_lvl", btn_level0, 0);
    check("single_rel_cnt", q0.size(), 1);

    // Bounce rejection
    do_reset();
    for (int k = 0; k < 2; k++) begin
      btn_in = 1'b1;
      step(2);
      btn_in = 1'b0;
      step(2);
    end
    step(10);
    check("bounce_q0", q0.size(), 0);
    check("bounce_q1", q1.size(), 0);
    check("bounce_lvl", {btn_level0, btn_level1}, 0);
    check("bounce_pc", {pulse_count0, pulse_count1}, 0);

    // Auto-repeat train, then release (release timed so its btn_s drop
    // coincides with the would-be pulse at offset 40)
    do_reset();
    btn_in = 1'b1;
    base   = cyc;
    wait_first1("rep_lat", base, p0);
    step(p0 + 37 - cyc);
    check("rep_lvl_hi", btn_level1, 1);
    btn_in = 1'b0;
    r      = cyc;
    fall   = -1;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (fall < 0 && !btn_level1) fall = cyc - r;
    end
    check("rep_rel_lat", fall, 7);
    check("rep_cnt", q1.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < q1.size()) check($sformatf("rep_off%0d", i), q1[i] - p0, exp_off[i]);
    end
    check("rep_single_cnt", q0.size(), 1);
    check("rep_pc", pulse_count1, 7);

    // Short release glitch while held: back to PRESSED, delay restarts
    do_reset();
    btn_in = 1'b1;
    base   = cyc;
    wait_first1("glitch_lat", base, p0);
    step(3);
    btn_in = 1'b0;
    drop   = 0;
    for (int i = 0; i < 2; i++) begin
      step(1);
      if (!btn_level1) drop++;
    end
    btn_in = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (!btn_level1) drop++;
    end
    check("glitch_lvl_drop", drop, 0);
    check("glitch_cnt", q1.size(), 2);
    if (q1.size() > 1) check("glitch_off", q1[1] - p0, 18);
    btn_in = 1'b0;
    step(12);

    // enable=0: no pulses, no counting, level still tracks
    do_reset();
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      btn_in = 1'b1;
      step(10);
      check($sformatf("en0_lvl_hi%0d", k), btn_level1, 1);
      btn_in = 1'b0;
      step(10);
      check($sformatf("en0_lvl_lo%0d", k), btn_level1, 0);
    end
    check("en0_q", q0.size() + q1.size(), 0);
    check("en0_pc", {pulse_count0, pulse_count1}, 0);

    // 256 short presses with enable=1: counter wraps to 0
    enable = 1'b1;
    for (int k = 0; k < 256; k++) begin
      btn_in = 1'b1;
      step(10);
      btn_in = 1'b0;
      step(10);
      if (k == 254) check("wrap_pc255", pulse_count1, 255);
    end
    check("wrap_pc_repeat", pulse_count1, 0);
    check("wrap_pc_single", pulse_count0, 0);
    check("wrap_q1", q1.size(), 256);

    // Asynchronous reset in the middle of REPEAT
    do_reset();
    btn_in = 1'b1;
    base   = cyc;
    wait_first1("arst_lat0", base, p0);
    step(12);
    check("arst_pre_lvl", btn_level1, 1);
    check("arst_pre_pc", pulse_count1, 2);
    #2 reset_n = 1'b0;
    #1;
    check("arst_single", {t_out0, btn_level0, pulse_count0}, 0);
    check("arst_repeat", {t_out1, btn_level1, pulse_count1}, 0);
    step(2);
    reset_n = 1'b1;
    q1.delete();
    prev1 = 1'b0;
    base  = cyc;
    wait_first1("arst_relat", base, p0);

    check("no_adjacent", adj_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
